// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the seven-segment scanner and its nibble decoder.
package seven_seg_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment bit order on the 7-bit bus: {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/nibble_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module nibble_to_seven_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    logic [SEG_G:SEG_A] w_lit;

    always_comb begin
        w_lit = '0;
        case (i_nibble)
            4'h0: w_lit = 7'h3F;
            4'h1: w_lit = 7'h06;
            4'h2: w_lit = 7'h5B;
            4'h3: w_lit = 7'h4F;
            4'h4: w_lit = 7'h66;
            4'h5: w_lit = 7'h6D;
            4'h6: w_lit = 7'h7D;
            4'h7: w_lit = 7'h07;
            4'h8: w_lit = 7'h7F;
            4'h9: w_lit = 7'h6F;
            4'hA: w_lit = 7'h77;
            4'hB: w_lit = 7'h7C;
            4'hC: w_lit = 7'h39;
            4'hD: w_lit = 7'h5E;
            4'hE: w_lit = 7'h79;
            4'hF: w_lit = 7'h71;
        endcase
    end

    // Common-anode display: a lit segment is driven low
    assign o_seg = ~w_lit;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with per-slot blanking guard,
// tear-free frame commit of new values and optional leading-zero suppression.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 3000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_leading,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    slot_state_t               r_state;
    logic [4*NUM_DIGITS-1:0]   r_shadow_val;
    logic                      r_pending;
    logic [4*NUM_DIGITS-1:0]   r_disp_val;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_en_n;
    logic                      r_frame_done;

    logic [CNT_W-1:0]          w_cnt_next;
    logic [IDX_W-1:0]          w_idx_next;
    slot_state_t               w_state_next;
    logic                      w_slot_wrap;
    logic                      w_frame_wrap;
    logic [3:0]                w_nibble;
    logic [6:0]                w_dec_seg;
    logic [NUM_DIGITS-1:0]     w_upper_zero;
    logic                      w_suppress;
    logic [6:0]                w_seg_next;
    logic                      w_dp_next;
    logic [NUM_DIGITS-1:0]     w_en_n_next;
    logic                      w_frame_done_next;

    // w_upper_zero[k] is high when nibbles k..NUM_DIGITS-1 of the display value are all zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign w_upper_zero[gi] = ~|r_disp_val[4*NUM_DIGITS-1:4*gi];
        end
    endgenerate

    assign w_suppress = blank_leading && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_nibble   = r_disp_val[{r_idx, 2'b00} +: 4];

    nibble_to_seven_seg u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        w_slot_wrap       = (r_cnt == CNT_LAST);
        w_frame_wrap      = w_slot_wrap && (r_idx == IDX_LAST);
        w_cnt_next        = w_slot_wrap ? '0 : r_cnt + 1'b1;
        w_idx_next        = r_idx;
        w_state_next      = (w_cnt_next < CNT_BLANK) ? ST_BLANK : ST_SHOW;
        w_seg_next        = SEG_BLANK;
        w_dp_next         = 1'b1;
        w_en_n_next       = '1;
        // Registered one cycle early so the pulse lands on the commit cycle itself
        w_frame_done_next = (r_idx == IDX_LAST) && (r_cnt == CNT_PRE);

        if (w_slot_wrap) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        if (r_state == ST_SHOW && !w_suppress) begin
            w_seg_next  = w_dec_seg;
            w_dp_next   = ~dp_in[r_idx];
            w_en_n_next = ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= ST_BLANK;
            r_shadow_val <= '0;
            r_pending    <= 1'b0;
            r_disp_val   <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_en_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_state      <= w_state_next;
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_en_n       <= w_en_n_next;
            r_frame_done <= w_frame_done_next;

            // A load landing on the wrap cycle bypasses the shadow and commits directly
            if (w_frame_wrap) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp_val   <= value_in;
                    r_shadow_val <= value_in;
                end else if (r_pending) begin
                    r_disp_val <= r_shadow_val;
                end
            end else if (load) begin
                r_shadow_val <= value_in;
                r_pending    <= 1'b1;
            end
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign digit_en_n = r_en_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a frame-level model predicts every output cycle; a monitor compares.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_leading;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_en_n;
    logic        frame_done;

    exp_t        exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          p          = 0;
    int          cyc        = 0;
    logic [15:0] frame_val  = '0;
    logic [15:0] last_val   = '0;
    logic [3:0]  cur_dp     = '0;
    logic        cur_bl     = 1'b0;
    logic [6:0]  seg_tab [16];

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .value_in      (value_in),
        .load          (load),
        .dp_in         (dp_in),
        .blank_leading (blank_leading),
        .seg_out       (seg_out),
        .dp_out        (dp_out),
        .digit_en_n    (digit_en_n),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and push the output expected on the following cycle
    task automatic step(input logic rst, input logic ld, input logic [15:0] v);
        exp_t e;
        int   d;
        int   c;
        logic sup;
        @(negedge clk);
        rst_n         = rst;
        load          = ld;
        value_in      = v;
        dp_in         = cur_dp;
        blank_leading = cur_bl;
        e = '{en: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
        if (!rst) begin
            p         = 0;
            frame_val = '0;
            last_val  = '0;
        end else begin
            d   = (p / RD) % ND;
            c   = p % RD;
            sup = cur_bl && (d != 0) && ((frame_val >> (4 * d)) == 16'h0);
            if (c >= BC && !sup) begin
                e.en    = 4'hF;
                e.en[d] = 1'b0;
                e.seg   = seg_tab[frame_val[4*d +: 4]];
                e.dp    = ~cur_dp[d];
            end
            e.fd = (((p + 1) % FRAME) == FRAME - 1);
            if (ld) begin
                last_val = v;
                $display("load 0x%04h at frame %0d slot %0d cnt %0d", v, p / FRAME, d, c);
            end
            if ((p % FRAME) == FRAME - 1) frame_val = last_val;
            p++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0);
    endtask

    task automatic goto_pos(input int t);
        while ((p % FRAME) != t) step(1'b1, 1'b0, 16'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (digit_en_n !== e.en || seg_out !== e.seg || dp_out !== e.dp || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL out cyc %0d: en=%b seg=%b dp=%b fd=%b, want en=%b seg=%b dp=%b fd=%b",
                         cyc, digit_en_n, seg_out, dp_out, frame_done, e.en, e.seg, e.dp, e.fd);
            end
        end
    end

    initial begin
        logic [15:0] v;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; blank_leading = 1'b0;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0);
        idle(40);

        step(1'b1, 1'b1, 16'h1234);
        idle(80);

        goto_pos(10);
        step(1'b1, 1'b1, 16'hABCD);
        goto_pos(18);
        step(1'b1, 1'b1, 16'h5678);
        idle(70);

        goto_pos(30);
        step(1'b1, 1'b1, 16'h1111);
        step(1'b1, 1'b1, 16'h9F0E);
        idle(40);

        cur_bl = 1'b1;
        step(1'b1, 1'b1, 16'h0005);
        idle(70);
        step(1'b1, 1'b1, 16'h0000);
        idle(70);
        step(1'b1, 1'b1, 16'h0300);
        idle(40);

        cur_bl = 1'b0;
        cur_dp = 4'b0100;
        step(1'b1, 1'b1, 16'h8421);
        idle(70);

        goto_pos(19);
        step(1'b1, 1'b1, 16'h4321);
        goto_pos(21);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
        idle(70);

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) == 0) cur_bl = ~cur_bl;
            if ($urandom_range(0, 49) == 0) cur_dp = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                step(1'b0, 1'b0, 16'h0);
            end else if ($urandom_range(0, 15) == 0) begin
                v = 16'($urandom);
                v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
                step(1'b1, 1'b1, v);
            end else begin
                step(1'b1, 1'b0, 16'($urandom));
            end
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
